// File: rtl/uart_pkg.sv
// Shared types and constants for the debug-dump UART frame transmitter.
// UART_FRAME_CKSUM_EN selects a 7-byte frame (with XOR checksum) or 6 bytes.
package uart_pkg;

  localparam logic [7:0] UART_HDR = 8'hA5;

  typedef enum logic [1:0] {
    KIND_REG   = 2'b00,
    KIND_ALU   = 2'b01,
    KIND_INST  = 2'b10,
    KIND_OTHER = 2'b11
  } kind_e;

`ifdef UART_FRAME_CKSUM_EN
  localparam int UART_FRAME_BYTES = 7;
`else
  localparam int UART_FRAME_BYTES = 6;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BITS,
    ST_STOP
  } tx_state_e;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
  } pkt_t;

  function automatic logic [7:0] pkt_byte(
    input pkt_t       p,
    input logic [2:0] idx
  );
    logic [7:0] b;
    case (idx)
      3'd1:    b = {1'b0, p.kind, p.addr};
      3'd2:    b = p.data[31:24];
      3'd3:    b = p.data[23:16];
      3'd4:    b = p.data[15:8];
      3'd5:    b = p.data[7:0];
      default: b = UART_HDR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 bit engine: start, eight data bits LSB first, stop, CLK_DIV clocks each.
// A byte offered on the last stop cycle follows with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       tx,
  output logic       byte_done,
  output logic       byte_near
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] NEAR = CW'(CLK_DIV - 2);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tick;

  assign tick      = cnt_q == LAST;
  assign byte_done = (state_q == ST_STOP) && tick;
  assign byte_near = (state_q == ST_STOP) && (cnt_q == NEAR);
  assign tx        = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != ST_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (byte_valid) begin
          state_d = ST_START;
          shift_d = byte_data;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_BITS;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      ST_BITS: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          // chain straight into the next start bit
          if (byte_valid) begin
            state_d = ST_START;
            shift_d = byte_data;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Packet-to-UART frame sequencer: A5, kind/addr, data MSB first.
// With UART_FRAME_CKSUM_EN an XOR checksum byte closes the frame.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_send_en,
  input  logic [31:0] data,
  input  logic [4:0]  addr,
  input  logic [1:0]  kind,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        drop
);

  localparam logic [2:0] IDX_LAST = 3'(UART_FRAME_BYTES - 1);

  pkt_t       pkt_q;
  logic [2:0] idx_q, idx_nxt;
  logic       busy_q, done_q, drop_q;
  logic       accept, last, advance;
  logic       byte_valid, byte_done, byte_near;
  logic [7:0] byte_data;

  assign accept     = uart_send_en && !busy_q;
  assign last       = idx_q == IDX_LAST;
  assign advance    = busy_q && byte_done && !last;
  assign byte_valid = accept || advance;
  assign idx_nxt    = idx_q + 3'd1;

  assign busy = busy_q;
  assign done = done_q;
  assign drop = drop_q;

`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] cksum_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cksum_q <= 8'd0;
    end else if (accept) begin
      cksum_q <= 8'd0;
    end else if (advance && idx_nxt != 3'd6) begin
      cksum_q <= cksum_q ^ byte_data;
    end
  end
`endif

  always_comb begin
    byte_data = pkt_byte(pkt_q, idx_nxt);
    if (accept) begin
      byte_data = UART_HDR;
    end
`ifdef UART_FRAME_CKSUM_EN
    else if (idx_nxt == 3'd6) begin
      byte_data = cksum_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      idx_q  <= 3'd0;
      pkt_q  <= '0;
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      // done covers the final stop-bit cycle
      done_q <= busy_q && last && byte_near;
      drop_q <= uart_send_en && busy_q;
      if (accept) begin
        busy_q <= 1'b1;
        idx_q  <= 3'd0;
        pkt_q  <= {kind, addr, data};
      end else if (busy_q && byte_done) begin
        if (last) begin
          busy_q <= 1'b0;
        end else begin
          idx_q <= idx_nxt;
        end
      end
    end
  end

  uart_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_byte (
    .clk       (clk),
    .resetn    (resetn),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .tx        (tx),
    .byte_done (byte_done),
    .byte_near (byte_near)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: UART line decoder, done/drop monitors.
// Works with UART_FRAME_CKSUM_EN defined or undefined.
module tb_uart_frame_tx;

  localparam int D = 8;
`ifdef UART_FRAME_CKSUM_EN
  localparam int F = 7;
`else
  localparam int F = 6;
`endif
  localparam int FL = F * 10 * D;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        uart_send_en = 1'b0;
  logic [31:0] data = '0;
  logic [4:0]  addr = '0;
  logic [1:0]  kind = '0;
  logic        tx, busy, done, drop;

  uart_frame_tx #(.CLK_DIV(D)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .uart_send_en(uart_send_en),
    .data        (data),
    .addr        (addr),
    .kind        (kind),
    .tx          (tx),
    .busy        (busy),
    .done        (done),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_byte_t;

  exp_byte_t bq[$];
  int        dq[$];
  int        drq[$];
  int        busy_until = 0;
  bit        scramble = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  // Reference frame: built from the byte list, each byte 10 bit-times long
  task automatic model_frame(input int e, input logic [31:0] d,
                             input logic [4:0] a, input logic [1:0] k);
    logic [7:0] fb [7];
    logic [7:0] ck;
    exp_byte_t  x;
    fb[0] = 8'hA5;
    fb[1] = {1'b0, k, a};
    for (int i = 0; i < 4; i++) fb[2+i] = 8'(d >> (24 - 8 * i));
    ck = 8'h00;
    for (int i = 1; i < 6; i++) ck = ck ^ fb[i];
    fb[6] = ck;
    for (int i = 0; i < F; i++) begin
      x.b = fb[i];
      x.t = e + i * 10 * D;
      bq.push_back(x);
    end
    dq.push_back(e + FL - 1);
    busy_until = e + FL;
  endtask

  // Request sampled at posedge e; called at a negedge
  task automatic drive_at(input int e, input logic [31:0] d,
                          input logic [4:0] a, input logic [1:0] k);
    int edge_n;
    while (cyc + 1 < e) @(negedge clk);
    edge_n       = cyc + 1;
    uart_send_en = 1'b1;
    data         = d;
    addr         = a;
    kind         = k;
    if (edge_n > busy_until) model_frame(edge_n, d, a, k);
    else drq.push_back(edge_n);
    @(negedge clk);
    uart_send_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (scramble && !uart_send_en) begin
      data = $urandom;
      addr = 5'($urandom);
      kind = 2'($urandom);
    end
  end

  int dpop;
  always @(negedge clk) begin
    if (resetn) begin
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          dpop = dq.pop_front();
          chk("done_time", cyc, dpop);
        end
      end
      if (drop) begin
        if (drq.size() == 0) chk("drop_unexpected", 1, 0);
        else begin
          dpop = drq.pop_front();
          chk("drop_time", cyc, dpop);
        end
      end
    end
  end

  bit         dbusy = 0;
  int         dstart, dt, bi;
  logic [7:0] dbyte;
  exp_byte_t  ex;
  always @(negedge clk) begin
    if (!resetn) begin
      dbusy = 0;
    end else if (!dbusy) begin
      if (tx === 1'b0) begin
        dbusy  = 1;
        dstart = cyc;
        dbyte  = 8'h00;
      end
    end else begin
      dt = cyc - dstart;
      if (dt >= D / 2 && (dt - D / 2) % D == 0) begin
        bi = (dt - D / 2) / D;
        if (bi == 0) chk("start_bit", 32'(tx), 0);
        else if (bi <= 8) dbyte[bi-1] = tx;
        else begin
          chk("stop_bit", 32'(tx), 1);
          if (bq.size() == 0) chk("byte_unexpected", 32'(dbyte), 32'hFFFF);
          else begin
            ex = bq.pop_front();
            chk("byte_value", 32'(dbyte), 32'(ex.b));
            chk("byte_start", dstart, ex.t);
          end
          dbusy = 0;
        end
      end
    end
  end

  int e0, r;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_drop", 32'(drop), 0);
    resetn = 1'b1;
    @(negedge clk);

    drive_at(cyc + 3, 32'h12345678, 5'd4, 2'b01);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_tx", 32'(tx), 0);

    e0 = busy_until + 5;
    drive_at(e0, 32'hFFFFFFFF, 5'h1F, 2'b11);
    drive_at(e0 + 100, $urandom, 5'($urandom), 2'($urandom));
    drive_at(e0 + FL - 1, $urandom, 5'($urandom), 2'($urandom));
    drive_at(e0 + FL, $urandom, 5'($urandom), 2'($urandom));
    drive_at(e0 + FL + 1, 32'hA5A50F0F, 5'd17, 2'b10);
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_tx", 32'(tx), 0);

    scramble = 1;
    for (int i = 0; i < 4; i++) begin
      e0 = busy_until + 1 + int'($urandom_range(0, 15));
      drive_at(e0, $urandom, 5'($urandom), 2'($urandom));
      r = int'($urandom_range(1, FL));
      drive_at(e0 + r, $urandom, 5'($urandom), 2'($urandom));
    end
    scramble = 0;

    e0 = busy_until + 3;
    drive_at(e0, 32'hDEADBEEF, 5'd9, 2'b00);
    while (cyc < e0 + 200) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    bq.delete();
    dq.delete();
    busy_until = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    drive_at(cyc + 2, 32'hCAFE0042, 5'd30, 2'b01);

    for (int i = 0; i < 2 * FL && (bq.size() + dq.size() + drq.size()) > 0; i++)
      @(negedge clk);
    chk("drain", 32'(bq.size() + dq.size() + drq.size()), 0);
    repeat (2) @(negedge clk);
    chk("end_busy", 32'(busy), 0);
    chk("end_tx", 32'(tx), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Downstream serializer for the debug-dump path: accepts one packet (kind, addr, 32-bit data) per enable pulse from the packet sequencer and transmits it on the UART TX line as a fixed byte frame. Each frame is a header byte, a kind/addr byte, four data bytes (MSB first) and an optional XOR checksum byte. Every byte uses 8N1 framing, LSB first. The block owns baud timing, framing and busy/done signalling, and sits between the packet sequencer and the board TX pin.

## Interface
- CLK_DIV, 434: clk cycles per UART bit (50 MHz / 115200); legal range 4..65535
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- uart_send_en  in  1  one-cycle request; packet fields sampled on the same edge
- data  in  32  packet payload
- addr  in  5  packet address
- kind  in  2  packet kind: 00 reg, 01 alu, 10 inst, 11 other
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- drop  out  1  one-cycle pulse when a request is rejected because busy is high

## Operation
- FSM states: IDLE, START, BITS, STOP.
  - IDLE: when uart_send_en=1, latch {kind, addr, data}, load byte index 0, go to START.
  - START: tx=0 for CLK_DIV cycles.
  - BITS: send 8 bits LSB first, each held CLK_DIV cycles.
  - STOP: tx=1 for CLK_DIV cycles. At the end of STOP, if this was the last byte, pulse done and go to IDLE; otherwise advance the byte index and go to START.
- Frame bytes, in order:
  - B0 = 0xA5
  - B1 = {1'b0, kind, addr}
  - B2..B5 = data[31:24], [23:16], [15:8], [7:0]
  - B6 = B1^B2^B3^B4^B5 (only when checksum is enabled)
- The checksum accumulates as bytes are loaded; it is never recomputed from the live inputs.
- Latched fields are frozen for the whole frame. Input changes during busy have no effect.
- uart_send_en while not in IDLE is ignored and drop pulses in the same cycle. There is no queuing.
- Outputs:
  - busy=1 in every state except IDLE.
  - done and drop are registered single-cycle pulses.
- Bit counter (3 bits) and byte index (3 bits) never wrap inside a frame. The baud counter is sized by $clog2(CLK_DIV).

## Timing
- Reset values: tx=1, busy=0, done=0, drop=0. All state returns to IDLE.
- Reset asserted mid-frame: tx=1 asynchronously. The partial frame is abandoned and is not resumed after release.
- Accept edge N: busy=1 and tx=0 from edge N+1.
- Each bit lasts exactly CLK_DIV cycles. There are no gaps between bytes: the stop bit of byte k is followed directly by the start bit of byte k+1.
- Frame length F = 7 bytes with checksum, 6 without.
- done is high for the cycle ending at edge N + F*10*CLK_DIV. busy falls at that same edge.
- A request in the done-high cycle is dropped. A request on the next cycle is accepted.
- Default timing: F=7 gives 30380 cycles, which fits inside the sequencer's 41656-cycle slot.

## Configuration
- UART_FRAME_CKSUM_EN
  - Defined: B6 checksum is appended, F=7.
  - Undefined: the frame ends after B5, F=6. The checksum register and its logic are not synthesized.

## Structure
- Shared package uart_pkg holds:
  - UART_HDR = 8'hA5
  - kind encodings KIND_REG/ALU/INST/OTHER
  - UART_FRAME_BYTES, which depends on UART_FRAME_CKSUM_EN
- Sub-module uart_byte_tx implements the START/BITS/STOP bit engine and the baud counter, with a byte-valid/byte-done handshake.
- The top level sequences bytes and computes the checksum.

## Test plan
- Basic frame: CLK_DIV=8, data=0x12345678, addr=4, kind=01, checksum enabled -> decoded bytes A5 24 12 34 56 78 2C; done exactly 560 cycles after the accept edge.
- Checksum off: same stimulus with UART_FRAME_CKSUM_EN undefined -> bytes A5 24 12 34 56 78; done at 480 cycles.
- Busy rejection: second uart_send_en at cycles 100 and 559 of a frame (data=0xFFFFFFFF) -> drop pulses both times; tx carries only the first frame.
- Back-to-back: request on the cycle after done -> accepted, start bit begins one cycle later, no idle bit between frames.
- Mid-frame reset: resetn low at cycle 200 -> tx=1 immediately, busy=0; new request after release -> full, correct frame.
- Input freeze: toggle data/addr/kind every cycle while busy -> transmitted bytes match the values latched at accept.
